// File: rtl/fwft_sync_fifo_cd_if.sv
// Request-queue handshake bundle between the port front end (master) and the
// first-word-fall-through FIFO (slave).
interface fwft_sync_fifo_cd_if #(
  parameter int WID   = 64,
  parameter int DEPTH = 32
);
  logic                     wr_en;
  logic [WID-1:0]           din;
  logic                     rd_en;
  logic [WID-1:0]           dout;
  logic                     data_valid;
  logic                     empty;
  logic                     full;
  logic                     almost_full;
  logic                     prog_full;
  logic [$clog2(DEPTH):0]   cnt;
  logic                     rst_busy;
  logic                     ocd;

  modport master (
    output wr_en, din, rd_en,
    input  dout, data_valid, empty, full, almost_full, prog_full, cnt, rst_busy, ocd
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, data_valid, empty, full, almost_full, prog_full, cnt, rst_busy, ocd
  );
endinterface

// File: rtl/fwft_sync_fifo_cd.sv
// Single-clock FWFT request FIFO with occupancy flags, a reset-busy window
// released by a falling-edge detector, and an output-change-detect strobe.
module fwft_sync_fifo_cd #(
  parameter int WID              = 64,
  parameter int DEPTH            = 32,
  parameter int PROG_FULL_THRESH = DEPTH - 5,
  parameter int RST_BUSY_CYCLES  = 4
) (
  input logic               clk,
  input logic               rst,
  fwft_sync_fifo_cd_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] PFULL_C   = CW'(PROG_FULL_THRESH);
  localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
  localparam logic [3:0]    BUSY_INIT = 4'(RST_BUSY_CYCLES);

  // Reject illegal configurations at elaboration time.
  generate
    if ((DEPTH < 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fwft_sync_fifo_cd: DEPTH must be a power of two and >= 16");
    end
    if ((RST_BUSY_CYCLES < 1) || (RST_BUSY_CYCLES > 15)) begin : g_bad_busy
      $error("fwft_sync_fifo_cd: RST_BUSY_CYCLES must be in 1..15");
    end
  endgenerate

  logic [WID-1:0] mem_q [DEPTH];

  logic [CW-1:0]  wptr_q, wptr_d;
  logic [CW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     busy_cnt_q, busy_cnt_d;
  logic           busy_dly_q, busy_dly_d;
  logic           rst_busy_q, rst_busy_d;
  logic [WID-1:0] dout_q, dout_d;
  logic           ocd_q, ocd_d;

  logic           empty_s;
  logic           full_s;
  logic           wr_fire_s;
  logic           rd_fire_s;
  logic           busy_s;
  logic           busy_fall_s;
  logic [WID-1:0] dout_s;

  // Occupancy flags and request qualification; rejected requests never touch state.
  always_comb begin
    empty_s   = (cnt_q == ZERO_C);
    full_s    = (cnt_q == DEPTH_C);
    wr_fire_s = bus.wr_en & ~full_s  & ~rst_busy_q & ~rst;
    rd_fire_s = bus.rd_en & ~empty_s & ~rst_busy_q & ~rst;
  end

  // Head word falls through combinationally; forced to zero when nothing is queued.
  always_comb begin
    dout_s = {WID{1'b0}};
    if (empty_s) begin
      dout_s = {WID{1'b0}};
    end else begin
      dout_s = mem_q[rptr_q[AW-1:0]];
    end
  end

  // Pointer and occupancy next state; the extra pointer MSB separates full from empty.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_fire_s) begin
      wptr_d = wptr_q + ONE_C;
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_fire_s) begin
      rptr_d = rptr_q + ONE_C;
    end else begin
      rptr_d = rptr_q;
    end
    cnt_d = wptr_d - rptr_d;
  end

  // Busy countdown and its falling-edge detector that releases rst_busy one edge later.
  always_comb begin
    busy_s = (busy_cnt_q != 4'd0);
    if (busy_s) begin
      busy_cnt_d = busy_cnt_q - 4'd1;
    end else begin
      busy_cnt_d = 4'd0;
    end
    busy_dly_d  = busy_s;
    busy_fall_s = busy_dly_q & ~busy_s;
    if (busy_fall_s) begin
      rst_busy_d = 1'b0;
    end else begin
      rst_busy_d = rst_busy_q;
    end
  end

  // Output-change detect compares the current head against last cycle's head.
  always_comb begin
    dout_d = dout_s;
    ocd_d  = (dout_s != dout_q);
  end

  // Control state with synchronous reset that also restarts the busy window.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= ZERO_C;
      rptr_q     <= ZERO_C;
      cnt_q      <= ZERO_C;
      busy_cnt_q <= BUSY_INIT;
      busy_dly_q <= 1'b1;
      rst_busy_q <= 1'b1;
      dout_q     <= {WID{1'b0}};
      ocd_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      busy_cnt_q <= busy_cnt_d;
      busy_dly_q <= busy_dly_d;
      rst_busy_q <= rst_busy_d;
      dout_q     <= dout_d;
      ocd_q      <= ocd_d;
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_q[wptr_q[AW-1:0]] <= bus.din;
    end
  end

  assign bus.dout        = dout_s;
  assign bus.data_valid  = ~empty_s;
  assign bus.empty       = empty_s;
  assign bus.full        = full_s;
  assign bus.almost_full = (cnt_q >= AFULL_C);
  assign bus.prog_full   = (cnt_q >= PFULL_C);
  assign bus.cnt         = cnt_q;
  assign bus.rst_busy    = rst_busy_q;
  assign bus.ocd         = ocd_q;

endmodule

// File: tb/tb_fwft_sync_fifo_cd.sv
// Scoreboard bench for the FWFT request FIFO: the driver pushes accepted
// writes into an expected-data queue, the monitor pops on every read and
// checks data plus all flags against a queue-based reference.
module tb_fwft_sync_fifo_cd;

  localparam int WID   = 64;
  localparam int DEPTH = 32;
  localparam int PFT   = DEPTH - 5;
  localparam int RBC   = 4;

  logic clk;
  logic rst;

  fwft_sync_fifo_cd_if #(.WID(WID), .DEPTH(DEPTH)) bus ();

  fwft_sync_fifo_cd #(
    .WID(WID), .DEPTH(DEPTH), .PROG_FULL_THRESH(PFT), .RST_BUSY_CYCLES(RBC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [WID-1:0] exp_q[$];
  logic           m_busy;
  int             edges_since_rst;
  logic           mon_on;

  int n_cmp;
  int n_err;

  task automatic chk(input string name, input logic [WID-1:0] act, input logic [WID-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock of stimulus plus the model update it implies
  task automatic step(input logic r, input logic w, input logic [WID-1:0] d, input logic rd);
    logic wr_acc;
    @(negedge clk);
    rst       = r;
    bus.wr_en = w;
    bus.din   = d;
    bus.rd_en = rd;
    wr_acc = w && !r && !m_busy && (exp_q.size() < DEPTH);
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      edges_since_rst = 0;
      m_busy = 1'b1;
      mon_on = 1'b1;
    end else begin
      edges_since_rst++;
      m_busy = (edges_since_rst < RBC + 1);
      if (wr_acc) exp_q.push_back(d);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr_seq(input int n, input int base);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, WID'(base + i), 1'b0);
  endtask

  task automatic rd_seq(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
  endtask

  // monitor: flag checks every cycle, scoreboard pop on each acknowledged read
  logic [WID-1:0] p1, p2;
  initial begin
    p1 = '0;
    p2 = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_on) begin
        int n;
        logic [WID-1:0] cur;
        n   = exp_q.size();
        cur = (n != 0) ? exp_q[0] : '0;
        chk("cnt",         WID'(bus.cnt),         WID'(n));
        chk("empty",       WID'(bus.empty),       WID'(n == 0));
        chk("full",        WID'(bus.full),        WID'(n == DEPTH));
        chk("almost_full", WID'(bus.almost_full), WID'(n >= DEPTH - 1));
        chk("prog_full",   WID'(bus.prog_full),   WID'(n >= PFT));
        chk("data_valid",  WID'(bus.data_valid),  WID'(n != 0));
        chk("rst_busy",    WID'(bus.rst_busy),    WID'(m_busy));
        chk("ocd",         WID'(bus.ocd),         WID'(p1 != p2));
        chk("dout",        bus.dout,              cur);
        if (bus.rd_en && !rst && !m_busy && n != 0) begin
          chk("pop_data", bus.dout, exp_q.pop_front());
        end
        p2 = rst ? '0 : p1;
        p1 = rst ? '0 : cur;
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    mon_on = 1'b0;
    m_busy = 1'b1;
    edges_since_rst = 0;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;

    // reset, then write attempts during the busy window are dropped
    do_reset(3);
    for (int i = 0; i < RBC + 1; i++) step(1'b0, 1'b1, 64'hDEAD, 1'b0);
    idle(2);

    // single write / read with the ocd strobe
    step(1'b0, 1'b1, 64'hA5, 1'b0);
    idle(3);
    rd_seq(1);
    idle(2);

    // fill to full, overflow attempt, drain in order
    wr_seq(DEPTH, 0);
    step(1'b0, 1'b1, 64'hFF, 1'b0);
    rd_seq(DEPTH);
    idle(1);

    // pointer wrap-around
    wr_seq(20, 200);
    rd_seq(20);
    wr_seq(20, 100);
    idle(1);

    // simultaneous read and write at occupancy 5
    rd_seq(15);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, WID'(300 + i), 1'b1);
    // full plus read: write refused
    wr_seq(DEPTH - 5, 400);
    step(1'b0, 1'b1, 64'h777, 1'b1);
    rd_seq(DEPTH);
    // empty plus write: read ignored
    step(1'b0, 1'b1, 64'h55, 1'b1);
    rd_seq(1);

    // repeated identical words: pops expose equal heads, so no ocd
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 64'h33, 1'b0);
    rd_seq(4);

    // reset mid-operation at occupancy 12
    wr_seq(12, 500);
    do_reset(2);
    idle(RBC + 2);
    wr_seq(3, 600);
    rd_seq(4);

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic r, w, rd;
      logic [WID-1:0] d;
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 50);
      d  = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) d = 64'h1234;
      step(r, w, d, rd);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
